// File: rtl/dac_cfg_sequencer.sv
// dac_cfg_sequencer: round-robin arbiter and strobe generator for the
// shared dac_driver GPIO config bus. Optional stats: DAC_CFG_SEQ_STATS_EN.
module dac_cfg_sequencer #(
  parameter int NUM_REQ    = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 5,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             gpio_out,
  output logic                    busy,
  output logic [IW-1:0]           grant_idx
`ifdef DAC_CFG_SEQ_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]   wr_count
`endif
);

  if (NUM_REQ < 1 || NUM_REQ > 8 ||
      SETUP_CYC < 1 || SETUP_CYC > 255 ||
      STROBE_CYC < 1 || STROBE_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_param
    $error("dac_cfg_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [23:0]   bus_q, bus_d;
  logic          wclk_q, wclk_d;

  logic          found;
  logic [IW-1:0] win;

  // Round-robin search from rr_q, wrapping modulo NUM_REQ
  always_comb begin : p_arb
    int j;
    logic [NUM_REQ-1:0] sh;
    j     = 0;
    sh    = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sh = req_valid >> j;
      if (!found && sh[0]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // One-hot accept, only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && found)
      req_ready = NUM_REQ'(1) << win;
  end

  // Next-state, phase counter and bus capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    bus_d   = bus_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == win)
              bus_d = {req_data[8*i+:8], req_addr[16*i+:16]};
          end
          gidx_d  = win;
          if (int'(win) == NUM_REQ - 1) rr_d = '0;
          else rr_d = win + 1'b1;
          state_d = SETUP;
          cnt_d   = 8'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = STROBE;
          cnt_d   = 8'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = 8'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else cnt_d = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    wclk_d = (state_d == STROBE);
  end

  // State and registered bus; reset drops w_clk immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
      bus_q   <= '0;
      wclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      bus_q   <= bus_d;
      wclk_q  <= wclk_d;
    end
  end

  assign gpio_out  = {7'b0, wclk_q, bus_q};
  assign busy      = (state_q != IDLE);
  assign grant_idx = gidx_q;

`ifdef DAC_CFG_SEQ_STATS_EN
  logic [31:0] wr_q [NUM_REQ];
  logic [31:0] wr_d [NUM_REQ];
  logic        wr_done;

  assign wr_done = (state_q == HOLD) && (cnt_q == 8'd0);

  // Count a write as it leaves HOLD
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_d[i] = wr_q[i];
      if (wr_done && IW'(i) == gidx_q)
        wr_d[i] = wr_q[i] + 32'd1;
    end
  end

  // Per-requester completed-write counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) wr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) wr_q[i] <= wr_d[i];
    end
  end

  // Flatten counters onto the output port
  always_comb begin
    wr_count = '0;
    for (int i = 0; i < NUM_REQ; i++)
      wr_count[32*i+:32] = wr_q[i];
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// Scoreboard bench for dac_cfg_sequencer: u0 default timing (directed),
// u1 SETUP=3/STROBE=1/HOLD=1 with random traffic.
module tb_dac_cfg_sequencer;
  localparam int N = 2;

  typedef struct {
    int          g;
    logic [15:0] a;
    logic [7:0]  dt;
    int          t;
  } exp_t;

  logic            clk;
  logic [1:0]      rst;
  logic [N-1:0]    vld [2];
  logic [16*N-1:0] adr [2];
  logic [8*N-1:0]  dat [2];
  logic [N-1:0]    rdy [2];
  logic [31:0]     gpo [2];
  logic            bsy [2];
  logic [0:0]      gix [2];
`ifdef DAC_CFG_SEQ_STATS_EN
  logic [32*N-1:0] wc  [2];
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int free_at [2];
  int rr      [2];
  int egix    [2];
  int acnt    [2][N];
  int acc_cnt [2];
  int acc_g   [2];
  bit pw      [2];
  int width   [2];
  logic [23:0] held [2];
  exp_t q0[$];
  exp_t q1[$];
  bit rnd_done;

  dac_cfg_sequencer #(
    .NUM_REQ(N), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(5)
  ) u0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(vld[0]), .req_addr(adr[0]), .req_data(dat[0]),
    .req_ready(rdy[0]), .gpio_out(gpo[0]), .busy(bsy[0]),
    .grant_idx(gix[0])
`ifdef DAC_CFG_SEQ_STATS_EN
    , .wr_count(wc[0])
`endif
  );

  dac_cfg_sequencer #(
    .NUM_REQ(N), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(1)
  ) u1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(vld[1]), .req_addr(adr[1]), .req_data(dat[1]),
    .req_ready(rdy[1]), .gpio_out(gpo[1]), .busy(bsy[1]),
    .grant_idx(gix[1])
`ifdef DAC_CFG_SEQ_STATS_EN
    , .wr_count(wc[1])
`endif
  );

  function automatic int s_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction
  function automatic int st_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int h_of(input int d);
    return (d == 0) ? 5 : 1;
  endfunction

  task automatic chk(input int d, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got 0x%0h expected 0x%0h @cyc %0d",
               d, nm, act, exp, cyc);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic q_pop(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  task automatic q_clear(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endtask

  // Reference model and monitor, evaluated mid-cycle
  task automatic step(input int d);
    logic [N-1:0] er;
    int   g, j, per;
    exp_t e;
    logic w;
    per = s_of(d) + st_of(d) + h_of(d) + 1;
    if (rst[d]) begin
      free_at[d] = 0;
      rr[d]      = 0;
      egix[d]    = 0;
      for (int i = 0; i < N; i++) acnt[d][i] = 0;
      q_clear(d);
      pw[d] = 0;
      chk(d, "rst_ready", rdy[d], 0);
      chk(d, "rst_gpio", gpo[d], 0);
      chk(d, "rst_busy", bsy[d], 0);
      return;
    end
    chk(d, "busy", bsy[d], cyc < free_at[d]);
    chk(d, "grant_idx", gix[d], egix[d]);
    chk(d, "gpio_hi_zero", gpo[d][31:25], 0);
    er = '0;
    g  = -1;
    if (cyc >= free_at[d]) begin
      for (int k = 0; k < N; k++) begin
        j = (rr[d] + k) % N;
        if (g < 0 && vld[d][j]) g = j;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk(d, "ready", rdy[d], er);
    if (g >= 0) begin
      e.g  = g;
      e.a  = adr[d][16*g+:16];
      e.dt = dat[d][8*g+:8];
      e.t  = cyc;
      q_push(d, e);
      free_at[d] = cyc + per;
      rr[d]      = (g + 1) % N;
      egix[d]    = g;
      acnt[d][g]++;
      acc_g[d] = g;
      acc_cnt[d]++;
    end
    w = gpo[d][24];
    if (w && !pw[d]) begin
      chk(d, "strobe_expected", q_size(d) > 0, 1);
      if (q_size(d) > 0) begin
        q_pop(d, e);
        chk(d, "strobe_bus", gpo[d][23:0], {e.dt, e.a});
        chk(d, "strobe_time", cyc, e.t + s_of(d) + 1);
      end
      width[d] = 1;
      held[d]  = gpo[d][23:0];
    end else if (w && pw[d]) begin
      width[d]++;
      chk(d, "strobe_stable", gpo[d][23:0], held[d]);
    end else if (!w && pw[d]) begin
      chk(d, "strobe_width", width[d], st_of(d));
    end
    pw[d] = w;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) step(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int d, input int max);
    int b, n;
    b = acc_cnt[d];
    n = 0;
    while (acc_cnt[d] == b && n < max) begin
      tick();
      n++;
    end
    chk(d, "accept_seen", acc_cnt[d] != b, 1);
  endtask

  // Random traffic on u1 until 1000 writes are accepted
  initial begin : p_rnd
    int seen, n;
    vld[1]   = '0;
    adr[1]   = '0;
    dat[1]   = '0;
    rnd_done = 1'b0;
    @(negedge rst[1]);
    seen = acc_cnt[1];
    n    = 0;
    while (acc_cnt[1] < 1000 && n < 20000) begin
      tick();
      n++;
      if (acc_cnt[1] != seen) begin
        seen = acc_cnt[1];
        vld[1][acc_g[1]] = 1'b0;
      end
      if (acc_cnt[1] < 1000) begin
        for (int i = 0; i < N; i++) begin
          if (!vld[1][i]) begin
            if ($urandom_range(0, 2) == 0) begin
              vld[1][i]         = 1'b1;
              adr[1][16*i+:16]  = 16'($urandom);
              dat[1][8*i+:8]    = 8'($urandom);
            end
          end else if ($urandom_range(0, 15) == 0) begin
            vld[1][i] = 1'b0;
          end
        end
      end
    end
    vld[1] = '0;
    chk(1, "rnd_accepts", acc_cnt[1], 1000);
    rnd_done = 1'b1;
  end

  // Directed sequence on u0, then final drain and counter checks
  initial begin : p_main
    int g, n, sum;
    rst    = 2'b11;
    vld[0] = 2'b11;
    adr[0] = '0;
    dat[0] = '0;
    for (int d = 0; d < 2; d++) begin
      free_at[d] = 0; rr[d] = 0; egix[d] = 0;
      acc_cnt[d] = 0; acc_g[d] = 0; pw[d] = 0; width[d] = 0;
      held[d] = '0;
      for (int i = 0; i < N; i++) acnt[d][i] = 0;
    end
    repeat (5) @(posedge clk);
    #1;
    rst    = 2'b00;
    vld[0] = '0;
    tick();

    adr[0][15:0] = 16'h0003;
    dat[0][7:0]  = 8'h01;
    vld[0]       = 2'b01;
    wait_acc(0, 20);
    vld[0] = '0;
    chk(0, "setup_bus", gpo[0], 32'h00010003);
    tick();
    chk(0, "strobe_bus1", gpo[0], 32'h01010003);
    tick();
    chk(0, "strobe_bus2", gpo[0], 32'h01010003);
    tick();
    chk(0, "hold_bus", gpo[0], 32'h00010003);
    repeat (4) tick();
    chk(0, "busy_last", bsy[0], 1);
    tick();
    chk(0, "busy_drop", bsy[0], 0);

    rst[0] = 1'b1;
    tick();
    tick();
    rst[0] = 1'b0;
    adr[0] = {16'h2000, 16'h1000};
    dat[0] = {8'hB0, 8'hA0};
    vld[0] = 2'b11;
    for (int k = 0; k < 8; k++) begin
      wait_acc(0, 20);
      chk(0, "contention_grant", gix[0], k % 2);
      g = acc_g[0];
      adr[0][16*g+:16] = 16'(16'h1000 * (g + 1) + k + 1);
      dat[0][8*g+:8]   = 8'(dat[0][8*g+:8] + 1);
    end
    vld[0] = '0;
    repeat (10) tick();

    adr[0] = {16'h0AAA, 16'h0055};
    dat[0] = {8'hAA, 8'h55};
    vld[0] = 2'b01;
    wait_acc(0, 20);
    vld[0] = '0;
    tick();
    tick();
    vld[0][1] = 1'b1;
    tick();
    vld[0][1] = 1'b0;
    repeat (12) tick();
    chk(0, "withdraw_idle", bsy[0], 0);
    chk(0, "withdraw_bus", gpo[0], 32'h00550055);

    adr[0] = {16'h0888, 16'h0123};
    dat[0] = {8'h88, 8'h45};
    vld[0] = 2'b01;
    wait_acc(0, 20);
    vld[0] = '0;
    tick();
    chk(0, "pre_rst_wclk", gpo[0][24], 1);
    #1 rst[0] = 1'b1;
    #1 chk(0, "rst_wclk_drop", gpo[0][24], 0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    adr[0] = {16'h0888, 16'h0777};
    dat[0] = {8'h88, 8'h77};
    vld[0] = 2'b11;
    wait_acc(0, 20);
    vld[0] = '0;
    chk(0, "post_rst_grant", gix[0], 0);
    repeat (10) tick();
    chk(0, "post_rst_bus", gpo[0], 32'h00770777);
`ifdef DAC_CFG_SEQ_STATS_EN
    chk(0, "wr_count_r0", wc[0][31:0], 1);
    chk(0, "wr_count_r1", wc[0][63:32], 0);
`endif

    n = 0;
    while (!rnd_done && n < 30000) begin
      tick();
      n++;
    end
    chk(1, "rnd_finished", rnd_done, 1);
    repeat (10) tick();
    chk(0, "queue_drain", q_size(0), 0);
    chk(1, "queue_drain", q_size(1), 0);
`ifdef DAC_CFG_SEQ_STATS_EN
    sum = 0;
    for (int i = 0; i < N; i++) begin
      chk(1, "wr_count", wc[1][32*i+:32], acnt[1][i]);
      sum += int'(wc[1][32*i+:32]);
    end
    chk(1, "wr_count_sum", sum, 1000);
`else
    sum = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
